bcd_mod_counter: RTL and testbench

//   Parametrised synchronous modulo-N BCD counter, the general successor to the fixed mod-60 clock counter.

---
 rtl/bcd_counter_pkg.sv | 47 ++++
 rtl/bcd_digit.sv | 62 ++++++
 rtl/bcd_mod_counter.sv | 130 +++++++++++++
 tb/tb_bcd_mod_counter.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/bcd_counter_pkg.sv
// ============================================================================
// Package     : bcd_counter_pkg
// Description : Shared constants and helper functions for the parametrised
//               BCD modulo counter. int_to_bcd builds packed-BCD constants at
//               elaboration time and bcd_valid checks every digit is 0..9.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package bcd_counter_pkg;

    localparam int BCD_W      = 4;
    localparam int MAX_DIGITS = 4;

    // Convert a binary integer into packed BCD, digit 0 in [3:0]. Digits at
    // or above 'digits' are left at zero.
    function automatic logic [BCD_W*MAX_DIGITS-1:0] int_to_bcd(input int value,
                                                                input int digits);
        logic [BCD_W*MAX_DIGITS-1:0] r;
        int v;
        r = '0;
        v = value;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (i < digits) begin
                r[i*BCD_W +: BCD_W] = 4'(v % 10);
                v = v / 10;
            end
        end
        return r;
    endfunction

    // True when each of the low 'digits' nibbles of vec is a legal decimal digit.
    function automatic logic bcd_valid(input logic [BCD_W*MAX_DIGITS-1:0] vec,
                                       input int digits);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if ((i < digits) && (vec[i*BCD_W +: BCD_W] > 4'd9)) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage : bcd_counter_pkg

`default_nettype wire

// File: rtl/bcd_digit.sv
// ============================================================================
// Module      : bcd_digit
// Description : One decade cell (0..9) of the BCD counter.
//   clk  in  clock              rst in  async active-high reset -> RST_VAL
//   ci   in  step request       up  in  1 = increment, 0 = decrement
//   clr  in  sync clear to 0    ld  in  sync load of d
//   d    in  digit to load      q   out current digit
//   co   out carry (up, q==9) / borrow (down, q==0) qualified by ci
//   Priority: clr > ld > ci.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_digit
    import bcd_counter_pkg::*;
#(
    parameter logic [BCD_W-1:0] RST_VAL = 4'd0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ci,
    input  logic             up,
    input  logic             clr,
    input  logic             ld,
    input  logic [BCD_W-1:0] d,
    output logic [BCD_W-1:0] q,
    output logic             co
);

    logic [BCD_W-1:0] digit_q;
    logic [BCD_W-1:0] digit_d;

    always_comb begin
        digit_d = digit_q;
        if (clr) begin
            digit_d = '0;
        end else if (ld) begin
            digit_d = d;
        end else if (ci) begin
            if (up) begin
                digit_d = (digit_q >= 4'd9) ? 4'd0 : digit_q + 4'd1;
            end else begin
                digit_d = (digit_q == 4'd0) ? 4'd9 : digit_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit_q <= RST_VAL;
        end else begin
            digit_q <= digit_d;
        end
    end

    // Ripple enable to the next decade: this digit is about to roll over.
    assign co = ci & (up ? (digit_q == 4'd9) : (digit_q == 4'd0));
    assign q  = digit_q;

endmodule : bcd_digit

`default_nettype wire

// File: rtl/bcd_mod_counter.sv
// ============================================================================
// Module      : bcd_mod_counter
// Description : Parametrised synchronous modulo-MODULUS packed-BCD counter
//               with count enable, synchronous validated parallel load and a
//               combinational cascade carry.
//   clk      in   clock (rising edge)
//   rst      in   asynchronous active-high reset, q -> RESET_VAL
//   en       in   count enable (chain from the lower stage's co)
//   dn       in   count direction, 1 = down (only with BCD_COUNTER_DOWN_EN)
//   load     in   synchronous load strobe, priority over en
//   load_val in   BCD value to load
//   q        out  current count, digit 0 in [3:0]
//   co       out  combinational terminal-count carry
//   wrap     out  registered one-cycle pulse after a wrap
//   load_err out  registered one-cycle pulse after a rejected load
// Configuration macro: BCD_COUNTER_DOWN_EN adds the dn port and down counting.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_mod_counter
    import bcd_counter_pkg::*;
#(
    parameter int DIGITS    = 2,
    parameter int MODULUS   = 60,
    parameter int RESET_VAL = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
`ifdef BCD_COUNTER_DOWN_EN
    input  logic                  dn,
`endif
    input  logic                  load,
    input  logic [BCD_W*DIGITS-1:0] load_val,
    output logic [BCD_W*DIGITS-1:0] q,
    output logic                  co,
    output logic                  wrap,
    output logic                  load_err
);

    localparam int W = BCD_W * DIGITS;

    localparam logic [BCD_W*MAX_DIGITS-1:0] c_MAX_FULL = int_to_bcd(MODULUS - 1, DIGITS);
    localparam logic [BCD_W*MAX_DIGITS-1:0] c_RST_FULL = int_to_bcd(RESET_VAL, DIGITS);
    localparam logic [W-1:0]                c_MAX_BCD  = c_MAX_FULL[W-1:0];

    logic                       w_dn;
    logic                       w_step;
    logic                       w_term;
    logic                       w_ld_ok;
    logic [BCD_W*MAX_DIGITS-1:0] w_ld_ext;
    logic [W-1:0]               w_q;
    logic [DIGITS-1:0]          w_ci;
    logic [DIGITS-1:0]          w_dco;
    logic                       w_clr;
    logic                       w_ld;
    logic                       w_unused_top_co;

    logic                       wrap_q;
    logic                       load_err_q;

`ifdef BCD_COUNTER_DOWN_EN
    assign w_dn = dn;
`else
    assign w_dn = 1'b0;
`endif

    assign w_step = en & ~load;

    // Both operands are valid BCD here, so a plain unsigned compare of the
    // packed vectors orders them the same as their decimal values.
    always_comb begin
        w_ld_ext         = '0;
        w_ld_ext[W-1:0]  = load_val;
        w_ld_ok          = bcd_valid(w_ld_ext, DIGITS) && (load_val <= c_MAX_BCD);
    end

    assign w_term = w_dn ? (w_q == '0) : (w_q == c_MAX_BCD);
    assign co     = w_step & w_term;

    // Wrapping is done by forcing all digits at once rather than letting the
    // decade ripple run, because MODULUS need not be a power of ten.
    assign w_clr = (load & ~w_ld_ok) | (co & ~w_dn);
    assign w_ld  = (load &  w_ld_ok) | (co &  w_dn);

    generate
        for (genvar i = 0; i < DIGITS; i++) begin : g_digit
            if (i == 0) begin : g_first
                assign w_ci[i] = w_step;
            end else begin : g_chain
                assign w_ci[i] = w_dco[i-1];
            end

            bcd_digit #(
                .RST_VAL (c_RST_FULL[i*BCD_W +: BCD_W])
            ) u_digit (
                .clk (clk),
                .rst (rst),
                .ci  (w_ci[i]),
                .up  (~w_dn),
                .clr (w_clr),
                .ld  (w_ld),
                .d   (load ? load_val[i*BCD_W +: BCD_W] : c_MAX_BCD[i*BCD_W +: BCD_W]),
                .q   (w_q[i*BCD_W +: BCD_W]),
                .co  (w_dco[i])
            );
        end
    endgenerate

    // The top decade's carry has no consumer; wrap is decided by the modulus compare.
    assign w_unused_top_co = w_dco[DIGITS-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            wrap_q     <= co;
            load_err_q <= load & ~w_ld_ok;
        end
    end

    assign q        = w_q;
    assign wrap     = wrap_q;
    assign load_err = load_err_q;

endmodule : bcd_mod_counter

`default_nettype wire

// File: tb/tb_bcd_mod_counter.sv
// ============================================================================
// Module      : tb_bcd_mod_counter
// Description : Scoreboard bench for bcd_mod_counter. A seconds stage
//               (MODULUS=60) drives the enable of an hours stage (MODULUS=24)
//               through its co output. The driver pushes hand-computed
//               expectations; a negedge monitor pops and compares them.
//               With BCD_COUNTER_DOWN_EN defined a down-count sequence is added.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bcd_mod_counter;

    logic       clk;
    logic       rst;
    logic       en;
    logic       dn;
    logic       load;
    logic [7:0] load_val;
    logic [7:0] q;
    logic       co;
    logic       wrap;
    logic       load_err;

    logic       h_load;
    logic [7:0] h_load_val;
    logic [7:0] h_q;
    logic       h_co;
    logic       h_wrap;
    logic       h_load_err;

    typedef struct {
        logic [7:0] q;
        logic       co;
        logic       wrap;
        logic       lerr;
        logic [7:0] hq;
        logic       hwrap;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   n_pass;
    int   n_total;

    bcd_mod_counter #(.DIGITS(2), .MODULUS(60), .RESET_VAL(0)) u_sec (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
`ifdef BCD_COUNTER_DOWN_EN
        .dn       (dn),
`endif
        .load     (load),
        .load_val (load_val),
        .q        (q),
        .co       (co),
        .wrap     (wrap),
        .load_err (load_err)
    );

    bcd_mod_counter #(.DIGITS(2), .MODULUS(24), .RESET_VAL(0)) u_hr (
        .clk      (clk),
        .rst      (rst),
        .en       (co),
`ifdef BCD_COUNTER_DOWN_EN
        .dn       (1'b0),
`endif
        .load     (h_load),
        .load_val (h_load_val),
        .q        (h_q),
        .co       (h_co),
        .wrap     (h_wrap),
        .load_err (h_load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every negedge with a pending expectation is one comparison.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_total++;
            if (q === e.q && co === e.co && wrap === e.wrap && load_err === e.lerr &&
                h_q === e.hq && h_wrap === e.hwrap) begin
                n_pass++;
            end else begin
                $display("FAIL %s: got q=%h co=%b wrap=%b load_err=%b hq=%h hwrap=%b, expected q=%h co=%b wrap=%b load_err=%b hq=%h hwrap=%b",
                         e.tag, q, co, wrap, load_err, h_q, h_wrap,
                         e.q, e.co, e.wrap, e.lerr, e.hq, e.hwrap);
            end
        end
    end

    // One cycle: move to just after a rising edge, drive inputs, and record
    // what the monitor should see at the following negedge.
    task automatic cyc(input logic e, input logic l, input logic [7:0] lv,
                       input logic hl, input logic [7:0] hlv,
                       input logic [7:0] eq, input logic eco, input logic ew,
                       input logic eerr, input logic [7:0] ehq, input logic ehw,
                       input string tag);
        exp_t x;
        @(posedge clk);
        #1;
        en         = e;
        load       = l;
        load_val   = lv;
        h_load     = hl;
        h_load_val = hlv;
        x.q = eq; x.co = eco; x.wrap = ew; x.lerr = eerr;
        x.hq = ehq; x.hwrap = ehw; x.tag = tag;
        sb.push_back(x);
    endtask

    initial begin
        logic [7:0] bq;
        n_pass     = 0;
        n_total    = 0;
        rst        = 1'b1;
        en         = 1'b0;
        dn         = 1'b0;
        load       = 1'b0;
        load_val   = 8'h00;
        h_load     = 1'b0;
        h_load_val = 8'h00;

        // Reset state
        cyc(0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, "reset");
        rst = 1'b0;

        // Full mod-60 run
        for (int i = 0; i < 60; i++) begin
            bq = {4'(i / 10), 4'(i % 10)};
            cyc(1, 0, 8'h00, 0, 8'h00, bq, (i == 59), 0, 0, 8'h00, 0, "count_up");
        end
        cyc(0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 1, 0, 8'h01, 0, "wrap_59_00");
        cyc(0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0, 8'h01, 0, "wrap_one_cycle");

        // Load: valid, bad digit, out of range, boundary values
        cyc(1, 1, 8'h45, 0, 8'h00, 8'h00, 0, 0, 0, 8'h01, 0, "load45_issue");
        cyc(0, 0, 8'h00, 0, 8'h00, 8'h45, 0, 0, 0, 8'h01, 0, "load45_q");
        cyc(0, 1, 8'h4A, 0, 8'h00, 8'h45, 0, 0, 0, 8'h01, 0, "load4A_issue");
        cyc(0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 1, 8'h01, 0, "load4A_err");
        cyc(0, 1, 8'h61, 0, 8'h00, 8'h00, 0, 0, 0, 8'h01, 0, "load61_issue");
        cyc(0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 1, 8'h01, 0, "load61_err");
        cyc(0, 1, 8'h60, 0, 8'h00, 8'h00, 0, 0, 0, 8'h01, 0, "load60_issue");
        cyc(0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 1, 8'h01, 0, "load60_err");
        cyc(1, 1, 8'h59, 0, 8'h00, 8'h00, 0, 0, 0, 8'h01, 0, "load59_issue");
        cyc(0, 0, 8'h00, 0, 8'h00, 8'h59, 0, 0, 0, 8'h01, 0, "load59_q");

        // Enable toggling across a digit carry
        cyc(0, 1, 8'h09, 0, 8'h00, 8'h59, 0, 0, 0, 8'h01, 0, "load09_issue");
        cyc(1, 0, 8'h00, 0, 8'h00, 8'h09, 0, 0, 0, 8'h01, 0, "en_t0");
        cyc(0, 0, 8'h00, 0, 8'h00, 8'h10, 0, 0, 0, 8'h01, 0, "en_t1");
        cyc(1, 0, 8'h00, 0, 8'h00, 8'h10, 0, 0, 0, 8'h01, 0, "en_t2");
        cyc(0, 0, 8'h00, 0, 8'h00, 8'h11, 0, 0, 0, 8'h01, 0, "en_t3");
        cyc(0, 0, 8'h00, 0, 8'h00, 8'h11, 0, 0, 0, 8'h01, 0, "en_hold");

        // Cascade 23:59 -> 00:00
        cyc(0, 1, 8'h59, 1, 8'h23, 8'h11, 0, 0, 0, 8'h01, 0, "casc_load");
        cyc(1, 0, 8'h00, 0, 8'h00, 8'h59, 1, 0, 0, 8'h23, 0, "casc_2359");
        cyc(0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 1, 0, 8'h00, 1, "casc_0000");
        cyc(0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, "casc_after");

        // Asynchronous reset between edges
        cyc(0, 1, 8'h37, 1, 8'h12, 8'h00, 0, 0, 0, 8'h00, 0, "load37_issue");
        cyc(0, 0, 8'h00, 0, 8'h00, 8'h37, 0, 0, 0, 8'h12, 0, "load37_q");
        cyc(1, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, "async_rst");
        rst = 1'b1;
        cyc(1, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, "rst_release");
        rst = 1'b0;
        cyc(1, 0, 8'h00, 0, 8'h00, 8'h01, 0, 0, 0, 8'h00, 0, "resume_01");
        cyc(0, 0, 8'h00, 0, 8'h00, 8'h02, 0, 0, 0, 8'h00, 0, "resume_02");

`ifdef BCD_COUNTER_DOWN_EN
        // Down count through zero
        dn = 1'b1;
        cyc(0, 1, 8'h01, 0, 8'h00, 8'h02, 0, 0, 0, 8'h00, 0, "dn_load01");
        cyc(1, 0, 8'h00, 0, 8'h00, 8'h01, 0, 0, 0, 8'h00, 0, "dn_01");
        cyc(1, 0, 8'h00, 0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 0, "dn_00_co");
        cyc(0, 0, 8'h00, 0, 8'h00, 8'h59, 0, 1, 0, 8'h01, 0, "dn_wrap59");
        cyc(0, 0, 8'h00, 0, 8'h00, 8'h59, 0, 0, 0, 8'h01, 0, "dn_hold");
`endif

        // Drain the scoreboard with a bounded wait
        for (int k = 0; k < 10 && sb.size() > 0; k++) begin
            @(negedge clk);
            #1;
        end
        if (sb.size() != 0) begin
            n_total++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_bcd_mod_counter

`default_nettype wire
